// File: rtl/fxp8s_mat_feeder.sv
// Converts a byte-serial stream of two's-complement matrix elements to FXP8S
// sign-magnitude. Elements are packed two per row beat, and each operation
// delivers matrix A and then matrix B, zero-padded to exactly ROWS beats each.
module fxp8s_mat_feeder #(
  parameter int ROWS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_en,
  output logic        host_rdy,
  input  logic [7:0]  host_data,
  input  logic        host_last,
  output logic        out_en,
  input  logic        out_rdy,
  output logic        out_mat,
  output logic        out_mat_done,
  output logic [15:0] out_data,
  output logic        op_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int EW = $clog2(2 * ROWS);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(2 * ROWS - 1);

  typedef enum logic [1:0] {LD_A, PAD_A, LD_B, PAD_B} state_e;

  // 0x80 has no positive counterpart, so it saturates to magnitude 127.
  function automatic logic [7:0] to_fxp8s(input logic [7:0] x);
    logic [7:0] neg;
    logic [7:0] res;
    neg = -x;
    if (!x[7])            res = x;
    else if (x == 8'h80)  res = 8'hFF;
    else                  res = {1'b1, neg[6:0]};
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      pend_q, pend_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [RW-1:0]   row_q, row_d;
  logic            out_en_q, out_en_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            out_mat_q, out_mat_d;
  logic            out_done_q, out_done_d;
  logic            op_done_q, op_done_d;

  logic            ld_state;
  logic            slot_free;
  logic            accept;
  logic            in_b;
  logic            is_last_row;
  logic            mat_end;
  logic            load_beat;
  logic [15:0]     beat;
  logic [7:0]      conv;

  assign ld_state    = (state_q == LD_A) || (state_q == LD_B);
  assign slot_free   = ~out_en_q | out_rdy;
  assign host_rdy    = ld_state & slot_free & ~rst;
  assign accept      = host_en & host_rdy;
  assign in_b        = (state_q == LD_B) || (state_q == PAD_B);
  assign is_last_row = (row_q == LAST_ROW);
  assign conv        = to_fxp8s(host_data);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    elem_d     = elem_q;
    row_d      = row_q;
    load_beat  = 1'b0;
    beat       = 16'h0000;
    mat_end    = 1'b0;
    op_done_d  = out_en_q & out_rdy & out_mat_q & out_done_q;

    unique case (state_q)
      LD_A, LD_B: begin
        if (accept) begin
          mat_end = host_last | (elem_q == LAST_ELEM);
          if (elem_q[0] | host_last) begin
            load_beat = 1'b1;
            beat      = elem_q[0] ? {conv, pend_q} : {8'h00, conv};
          end else begin
            pend_d = conv;
          end
          elem_d = mat_end ? '0 : elem_q + 1'b1;
          if (mat_end && is_last_row) begin
            state_d = (state_q == LD_A) ? LD_B : LD_A;
            row_d   = '0;
          end else if (mat_end) begin
            state_d = (state_q == LD_A) ? PAD_A : PAD_B;
            row_d   = row_q + 1'b1;
          end else if (load_beat) begin
            row_d = row_q + 1'b1;
          end
        end
      end
      PAD_A, PAD_B: begin
        if (slot_free) begin
          load_beat = 1'b1;
          if (is_last_row) begin
            state_d = (state_q == PAD_A) ? LD_B : LD_A;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = LD_A;
    endcase

    // The output register drains on a transfer and reloads in the same cycle.
    out_en_d   = load_beat | (out_en_q & ~out_rdy);
    out_data_d = load_beat ? beat : out_data_q;
    out_mat_d  = load_beat ? in_b : out_mat_q;
    out_done_d = load_beat ? is_last_row : out_done_q;
  end

  // NOTE: reset is synchronous; every state register is cleared so a mid-stream reset drops all partial work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_A;
      pend_q     <= '0;
      elem_q     <= '0;
      row_q      <= '0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_mat_q  <= 1'b0;
      out_done_q <= 1'b0;
      op_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q    <= state_d;
      pend_q     <= pend_d;
      elem_q     <= elem_d;
      row_q      <= row_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      out_mat_q  <= out_mat_d;
      out_done_q <= out_done_d;
      op_done_q  <= op_done_d;
    end
  end

  assign out_en       = out_en_q;
  assign out_data     = out_data_q;
  assign out_mat      = out_mat_q;
  assign out_mat_done = out_done_q;
  assign op_done      = op_done_q;

endmodule

// File: doc/fxp8s_mat_feeder.md
# fxp8s_mat_feeder

Upstream feeder for `fxp8s_pe_block`. It accepts a byte-serial stream of two's-complement 8-bit matrix elements from the host side and converts each element to FXP8S sign-magnitude. It packs element pairs into 16-bit row beats, tags each beat with the target matrix, and drives the PE block's input stream. Every operation delivers matrix A and then matrix B, each as exactly ROWS beats; short matrices are zero-padded by this block.

## Interface
- `ROWS`, default 2: beats (rows) per matrix. There are 2 elements per beat, so one matrix holds 2*ROWS elements.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `host_en` in 1: host byte valid.
- `host_rdy` out 1: byte accepted when `host_en & host_rdy`.
- `host_data` in 8: two's-complement element, row-major order.
- `host_last` in 1: qualifies the accepted byte as the last element of the current matrix.
- `out_en` out 1: beat valid. Connects to PE `en_in_data`.
- `out_rdy` in 1: consumer ready. Connects to PE `rdy_in_data`. A beat transfers when `out_en & out_rdy`.
- `out_mat` out 1: 0 = matrix A, 1 = matrix B.
- `out_mat_done` out 1: high on the final beat (row ROWS-1) of each matrix.
- `out_data` out 16: [7:0] = column 0, [15:8] = column 1, both in FXP8S sign-magnitude.
- `op_done` out 1: one-cycle pulse in the cycle after the final B beat transfers.

## Operation
- States:
  - LD_A: collect A.
  - PAD_A: zero-fill A.
  - LD_B: collect B.
  - PAD_B: zero-fill B.
- Reset state is LD_A.
- Conversion of each accepted byte x:
  - x[7]=0: output is x unchanged.
  - x[7]=1: output is {1, (-x)[6:0]}.
  - x=0x80 saturates to 0xFF (sign 1, magnitude 127).
  - Negative zero is never produced.
- Packing:
  - Even-indexed element: held in a pending low-byte register.
  - Odd-indexed element: completes the beat {conv(odd), pending}, which is loaded into the output register.
- Matrix end is the first of two events:
  - an accepted byte with `host_last=1`;
  - the 2*ROWS-th accepted element (`host_last` is not required).
- `host_last` on an even element: the beat is loaded immediately with [15:8]=0x00.
- After the end-of-matrix beat:
  - If that beat was row ROWS-1: LD_A goes to LD_B; LD_B goes to LD_A and pulses `op_done`.
  - Otherwise: go to PAD_x.
- In PAD_x:
  - `host_rdy=0`.
  - A 0x0000 beat is loaded each cycle the output slot is free, until row ROWS-1 is loaded.
  - Then go to LD_B (from PAD_A) or LD_A (from PAD_B, pulsing `op_done`).
- Row counter:
  - Counts beats loaded in the current matrix, 0..ROWS-1.
  - Clears on matrix change.
  - `out_mat_done` for a loaded beat = (row == ROWS-1).
- `out_mat` = 0 for beats loaded in A states, 1 for beats loaded in B states.
- `host_rdy` = LD state & (~`out_en` | `out_rdy`) & ~`rst`. It stays conservative even when the pending register is empty.

## Timing
- Reset values:
  - `out_en`, `out_mat`, `out_mat_done`, `op_done` = 0.
  - `out_data` = 0x0000.
  - `host_rdy` = 0 while `rst` is high.
  - Pending byte, row counter and state are cleared.
- Reset mid-operation discards the pending byte and any beat not yet transferred. The first beat after reset is A row 0.
- Latency: the beat is visible on `out_en` one cycle after the accepting handshake of its completing byte. PAD beats appear one cycle after the slot frees.
- Throughput:
  - LD: 1 beat per 2 cycles.
  - PAD: 1 beat per cycle with `out_rdy` held high.
- While `out_en & ~out_rdy`, `out_data`, `out_mat` and `out_mat_done` are held stable and `host_rdy` = 0.
- The output register reloads in the same cycle it drains, with no bubble.
- Simultaneous drain and completing byte: the new beat replaces the old beat in that cycle.
- `op_done` is asserted for exactly one cycle per operation. It does not depend on `out_rdy` after the final transfer.

## Test plan
- **Full operation.** A = 0x01,0x02,0x03,0x04; B = 0x05..0x08 with `host_last` on 0x04 and 0x08; `out_rdy`=1. Expect these beats, then one `op_done` pulse:
  - 0x0201 (mat 0, done 0)
  - 0x0403 (mat 0, done 1)
  - 0x0605 (mat 1, done 0)
  - 0x0807 (mat 1, done 1)
- **Conversion.** A = 0xFF,0x80,0x90,0x7F. Expect beats 0xFF81 and 0x7FF0.
- **Early last.** A = 0x11 with `host_last`. Expect beats 0x0011 (done 0) then 0x0000 (done 1) on consecutive cycles, with `host_rdy`=0 during PAD_A. The next byte is B row 0.
- **Backpressure.** Drop `out_rdy` for 5 cycles while 0x0403 is valid. Expect `out_data`, `out_mat` and `out_mat_done` held stable, `host_rdy`=0, and no lost or duplicated beat.
- **Count terminate.** Send 4 A bytes without `host_last`, then 0x09. Expect the A beats to end with done=1 and 0x09 to land in B row 0 (mat 1).
- **Reset mid-B.** Assert `rst` for 1 cycle after B row 0 transfers. Next cycle expect `out_en`=0 and `op_done`=0. A fresh stream then produces `out_mat`=0 beats starting at row 0.
